// File: rtl/div_pkg.sv
// Shared constants and helpers for the restoring-division datapath.
package div_pkg;

  localparam int DIV_W = 32;
  localparam logic [5:0] FUNCT_SUB = 6'b001010;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_SUB  = 2'd1,
    ALU_ADD  = 2'd2
  } alu_op_e;

  function automatic alu_op_e decode_funct(input logic [5:0] funct);
    alu_op_e op;
    case (funct)
      FUNCT_SUB: op = ALU_SUB;
      FUNCT_ADD: op = ALU_ADD;
      default:   op = ALU_PASS;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/div_datapath_if.sv
// Operand/control/result bundle of the divider datapath.
// The dz flag exists only when DIV_DZ_DETECT_EN is defined.
interface div_datapath_if;
  import div_pkg::*;

  logic [DIV_W-1:0] dividend;
  logic [DIV_W-1:0] divisor;
  logic             w_ctrl_reg1;
  logic             w_ctrl_reg2;
  logic             SLL_ctrl;
  logic             SRL_ctrl;
  logic [5:0]       funct;
  logic [DIV_W-1:0] quotient;
  logic [DIV_W-1:0] remainder;
  logic             valid;

`ifdef DIV_DZ_DETECT_EN
  logic             dz;

  modport master (
    output dividend, divisor, w_ctrl_reg1, w_ctrl_reg2, SLL_ctrl, SRL_ctrl, funct,
    input  quotient, remainder, valid, dz
  );

  modport slave (
    input  dividend, divisor, w_ctrl_reg1, w_ctrl_reg2, SLL_ctrl, SRL_ctrl, funct,
    output quotient, remainder, valid, dz
  );
`else
  modport master (
    output dividend, divisor, w_ctrl_reg1, w_ctrl_reg2, SLL_ctrl, SRL_ctrl, funct,
    input  quotient, remainder, valid
  );

  modport slave (
    input  dividend, divisor, w_ctrl_reg1, w_ctrl_reg2, SLL_ctrl, SRL_ctrl, funct,
    output quotient, remainder, valid
  );
`endif

endinterface

// File: rtl/div_alu.sv
// 33-bit add/subtract unit; borrow is meaningful only for the SUB opcode.
module div_alu
  import div_pkg::*;
(
  input  logic [DIV_W:0] a,
  input  logic [DIV_W:0] b,
  input  logic [5:0]     funct,
  output logic [DIV_W:0] result,
  output logic           borrow
);

  logic [DIV_W+1:0] wide_s;
  alu_op_e          op_s;

  assign op_s = decode_funct(funct);

  // Extended-width arithmetic so the top bit carries the borrow.
  always_comb begin
    wide_s = {(DIV_W+2){1'b0}};
    case (op_s)
      ALU_SUB: wide_s = {1'b0, a} - {1'b0, b};
      ALU_ADD: wide_s = {1'b0, a} + {1'b0, b};
      default: wide_s = {1'b0, a};
    endcase
    result = wide_s[DIV_W:0];
    if (op_s == ALU_SUB) begin
      borrow = wide_s[DIV_W+1];
    end else begin
      borrow = 1'b0;
    end
  end

endmodule

// File: rtl/div_datapath.sv
// Restoring shift-subtract divider datapath driven by an external control FSM.
// Optional feature macro: DIV_DZ_DETECT_EN (divide-by-zero flag and zeroed result).
module div_datapath
  import div_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  div_datapath_if.slave bus
);

  logic [DIV_W:0]   rhi_r;
  logic [DIV_W-1:0] rlo_r;
  logic [DIV_W-1:0] dreg_r;
  logic [DIV_W-1:0] quotient_r;
  logic [DIV_W-1:0] remainder_r;
  logic             valid_r;
  logic [2*DIV_W:0] shift_s;
  logic [DIV_W:0]   diff_s;
  logic             borrow_s;
  logic             sub_step_s;

  // rhi_r[DIV_W] falls off the top: the window is {rhi[31:0], rlo} << 1.
  assign shift_s    = {rhi_r, rlo_r} << 1;
  assign sub_step_s = bus.SLL_ctrl && (bus.funct == FUNCT_SUB);

  div_alu u_alu (
    .a      (shift_s[2*DIV_W:DIV_W]),
    .b      ({1'b0, dreg_r}),
    .funct  (bus.funct),
    .result (diff_s),
    .borrow (borrow_s)
  );

  // Working register: load beats commit, commit freezes the iteration step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rhi_r <= {(DIV_W+1){1'b0}};
      rlo_r <= {DIV_W{1'b0}};
    end else if (bus.w_ctrl_reg1) begin
      rhi_r <= {(DIV_W+1){1'b0}};
      rlo_r <= bus.dividend;
    end else if (bus.SRL_ctrl) begin
      rhi_r <= rhi_r;
      rlo_r <= rlo_r;
    end else if (sub_step_s) begin
      if (!borrow_s) begin
        rhi_r <= diff_s;
        rlo_r <= {shift_s[DIV_W-1:1], 1'b1};
      end else begin
        rhi_r <= shift_s[2*DIV_W:DIV_W];
        rlo_r <= shift_s[DIV_W-1:0];
      end
    end
  end

  // Divisor register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dreg_r <= {DIV_W{1'b0}};
    end else if (bus.w_ctrl_reg2) begin
      dreg_r <= bus.divisor;
    end
  end

`ifdef DIV_DZ_DETECT_EN
  logic dz_r;

  // Committed result with divide-by-zero detection; a zero divisor yields 0/0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient_r  <= {DIV_W{1'b0}};
      remainder_r <= {DIV_W{1'b0}};
      valid_r     <= 1'b0;
      dz_r        <= 1'b0;
    end else if (bus.w_ctrl_reg1) begin
      valid_r <= 1'b0;
      dz_r    <= 1'b0;
    end else if (bus.SRL_ctrl) begin
      valid_r <= 1'b1;
      dz_r    <= (dreg_r == {DIV_W{1'b0}});
      if (dreg_r == {DIV_W{1'b0}}) begin
        quotient_r  <= {DIV_W{1'b0}};
        remainder_r <= {DIV_W{1'b0}};
      end else begin
        quotient_r  <= rlo_r;
        remainder_r <= rhi_r[DIV_W-1:0];
      end
    end
  end

  assign bus.dz = dz_r;
`else
  // Committed result; a zero divisor naturally gives all-ones / dividend.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient_r  <= {DIV_W{1'b0}};
      remainder_r <= {DIV_W{1'b0}};
      valid_r     <= 1'b0;
    end else if (bus.w_ctrl_reg1) begin
      valid_r <= 1'b0;
    end else if (bus.SRL_ctrl) begin
      valid_r     <= 1'b1;
      quotient_r  <= rlo_r;
      remainder_r <= rhi_r[DIV_W-1:0];
    end
  end
`endif

  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
  assign bus.valid     = valid_r;

endmodule
